interrupt_controller: RTL
=========================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter PC_W, default 14: program counter width in words.
REQ-002 Parameter VEC_STRIDE, default 2: word distance between adjacent vector slots.
REQ-003 clk  in  1  system clock (16 MHz sysClock domain).
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 tifr  in  8  combined timer interrupt flags {OCF2,TOV2,ICF1,OCF1A,OCF1B,TOV1,OCF0,TOV0}.
REQ-006 timsk  in  8  interrupt mask, same bit order as tifr.
REQ-007 sreg_i  in  1  global interrupt enable, SREG bit 7.
REQ-008 instr_done  in  1  control unit: instruction boundary this cycle.
REQ-009 reti  in  1  control unit: RETI executing this cycle.
REQ-010 pc  in  PC_W  return address, valid when instr_done=1.
REQ-011 ext_int  in  3  INT2..INT0 pins, used only with INTCTRL_EXT_INT_EN.
REQ-012 gicr_mask  in  3  INT2..INT0 enables, used only with INTCTRL_EXT_INT_EN.
REQ-013 push_req  out  1  stack write request.
REQ-014 push_data  out  8  byte to push.
REQ-015 push_ack  in  1  stack accepted push_data this cycle.
REQ-016 hold  out  1  stall fetch/PC increment.
REQ-017 pc_overwrite  out  1  one-cycle load strobe to program memory.
REQ-018 pc_new  out  PC_W  vector address.
REQ-019 flag_clr  out  8  one-hot tifr clear strobe.
REQ-020 sreg_i_clr  out  1  one-cycle pulse clearing SREG I.
REQ-021 sreg_i_set  out  1  one-cycle pulse setting SREG I.

Function
REQ-022 Pending set: pend = tifr & timsk; request when |pend and sreg_i=1.
REQ-023 Priority: highest set pend bit wins; bit n vector = 0x008 + VEC_STRIDE*(7-n), e.g. bit7->0x008, bit0->0x016.
REQ-024 States IDLE, PUSH_LO, PUSH_HI, VECTOR.
REQ-025 IDLE->PUSH_LO when instr_done=1, request true, reti=0; winner index and pc captured that cycle.
REQ-026 PUSH_LO: push_req=1, push_data=pc[7:0]; advance to PUSH_HI on push_ack, else remain.
REQ-027 PUSH_HI: push_req=1, push_data=zero-extended pc[PC_W-1:8]; advance to VECTOR on push_ack.
REQ-028 VECTOR (exactly one cycle): pc_overwrite=1, pc_new=captured vector, flag_clr=one-hot captured index, sreg_i_clr=1; then IDLE.
REQ-029 hold=1 in every non-IDLE state; 0 in IDLE.
REQ-030 Minimum latency instr_done to pc_overwrite: 3 cycles with push_ack tied high.
REQ-031 reti=1 in IDLE: sreg_i_set pulses next cycle; no request accepted that cycle (one instruction executes after RETI).
REQ-032 Flags rising after capture stay pending; never preempt a sequence in progress.
REQ-033 Request with sreg_i=0 or instr_done=0: no action; flag remains pending.
REQ-034 Capture is atomic: tifr/timsk changes after capture do not alter vector or flag_clr.

Reset
REQ-035 reset_n low forces IDLE immediately, mid-sequence included; all outputs 0, captured registers 0, edge-detect history 0.

Configuration
REQ-036 INTCTRL_EXT_INT_EN defined: ext_int rising edges latched into 3 internal flags, masked by gicr_mask, priority above all timer sources (INT0 0x002, INT1 0x004, INT2 0x006); VECTOR clears the latched flag, flag_clr=0.
REQ-037 INTCTRL_EXT_INT_EN undefined: ext_int and gicr_mask ignored, no edge logic synthesised.

Structure
REQ-038 Shared package: state encoding, vector base constants (0x002, 0x008), source index constants.
REQ-039 One sub-module: intc_priority_encoder (pending vector -> valid, index, vector address), combinational.

Verification
REQ-040 tifr=0x01, timsk=0x01, sreg_i=1, instr_done pulse, pc=0x0123, push_ack=1 -> pushes 0x23 then 0x01, pc_new=0x016, flag_clr=0x01, sreg_i_clr=1, hold 3 cycles.
REQ-041 tifr=0x11, timsk=0xFF -> pc_new=0x00E, flag_clr=0x10; second sequence on next boundary -> 0x016.
REQ-042 tifr=0x02, timsk=0x02, sreg_i=0 over 10 boundaries -> no push; set sreg_i=1 -> sequence begins next boundary.
REQ-043 push_ack held low 5 cycles in PUSH_LO -> push_data stays 0x23, hold stays 1, no pc_overwrite.
REQ-044 reset_n low in PUSH_HI -> all outputs 0 immediately; after release, IDLE, retakes pending flag at next boundary.
REQ-045 With INTCTRL_EXT_INT_EN, ext_int[0] rising, gicr_mask=0x1, tifr=0x80 -> pc_new=0x002 first, then 0x008.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the timer/external interrupt controller: FSM states,
// vector base addresses and source index constants.
package interrupt_controller_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PUSH_LO = 2'd1,
        PUSH_HI = 2'd2,
        VECTOR  = 2'd3
    } intc_state_e;

    localparam int VEC_BASE_EXT   = 'h002;
    localparam int VEC_BASE_TIMER = 'h008;

    // Timer sources follow the tifr bit order; TOV0 is lowest priority.
    localparam int SRC_TOV0 = 0;
    localparam int SRC_OCF2 = 7;
    localparam int SRC_INT0 = 0;
    localparam int SRC_INT2 = 2;

    function automatic int vecAddr(input logic isExt, input int idx, input int stride);
        return isExt ? (VEC_BASE_EXT + stride * idx)
                     : (VEC_BASE_TIMER + stride * (SRC_OCF2 - idx));
    endfunction

endpackage

// File: rtl/intc_priority_encoder.sv
// Combinational priority encoder: picks the winning pending source and its vector.
// External sources (INT0 highest) always beat timer sources (OCF2 highest).
module intc_priority_encoder
    import interrupt_controller_pkg::*;
#(
    parameter int PC_W       = 14,
    parameter int VEC_STRIDE = 2
) (
    input  logic [7:0]      timer_pend_i,
    input  logic [2:0]      ext_pend_i,
    output logic            valid_o,
    output logic            is_ext_o,
    output logic [2:0]      index_o,
    output logic [PC_W-1:0] vector_o
);

    // Later loop iterations override earlier ones, so scan order sets priority.
    always_comb begin
        valid_o  = 1'b0;
        is_ext_o = 1'b0;
        index_o  = '0;
        vector_o = '0;
        for (int i = SRC_TOV0; i <= SRC_OCF2; i++) begin
            if (timer_pend_i[i]) begin
                valid_o  = 1'b1;
                index_o  = 3'(i);
                vector_o = PC_W'(vecAddr(1'b0, i, VEC_STRIDE));
            end
        end
        for (int i = SRC_INT2; i >= SRC_INT0; i--) begin
            if (ext_pend_i[i]) begin
                valid_o  = 1'b1;
                is_ext_o = 1'b1;
                index_o  = 3'(i);
                vector_o = PC_W'(vecAddr(1'b1, i, VEC_STRIDE));
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: on an instruction boundary pushes the return PC and vectors.
// Define INTCTRL_EXT_INT_EN to add the INT0..INT2 edge-triggered external sources.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int PC_W       = 14,
    parameter int VEC_STRIDE = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [7:0]      tifr,
    input  logic [7:0]      timsk,
    input  logic            sreg_i,
    input  logic            instr_done,
    input  logic            reti,
    input  logic [PC_W-1:0] pc,
    input  logic [2:0]      ext_int,
    input  logic [2:0]      gicr_mask,
    output logic            push_req,
    output logic [7:0]      push_data,
    input  logic            push_ack,
    output logic            hold,
    output logic            pc_overwrite,
    output logic [PC_W-1:0] pc_new,
    output logic [7:0]      flag_clr,
    output logic            sreg_i_clr,
    output logic            sreg_i_set
);

    intc_state_e     state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic            ext_q, ext_d;
    logic [PC_W-1:0] vec_q, vec_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            reti_q;

    logic [2:0]      ext_pend;
    logic            enc_valid;
    logic            enc_is_ext;
    logic [2:0]      enc_index;
    logic [PC_W-1:0] enc_vector;
    logic            request;

`ifdef INTCTRL_EXT_INT_EN
    logic [2:0] ext_prev_q;
    logic [2:0] ext_flag_q, ext_flag_d;

    // A fresh edge wins over a same-cycle clear so no edge is ever lost.
    always_comb begin
        ext_flag_d = ext_flag_q;
        if (state_q == VECTOR && ext_q) begin
            ext_flag_d = ext_flag_d & ~(3'b001 << idx_q);
        end
        ext_flag_d = ext_flag_d | (ext_int & ~ext_prev_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext_prev_q <= '0;
            ext_flag_q <= '0;
        end else begin
            ext_prev_q <= ext_int;
            ext_flag_q <= ext_flag_d;
        end
    end

    assign ext_pend = ext_flag_q & gicr_mask;
`else
    logic unused_ext;
    assign unused_ext = ^{ext_int, gicr_mask};
    assign ext_pend   = '0;
`endif

    intc_priority_encoder #(
        .PC_W       (PC_W),
        .VEC_STRIDE (VEC_STRIDE)
    ) u_prio (
        .timer_pend_i (tifr & timsk),
        .ext_pend_i   (ext_pend),
        .valid_o      (enc_valid),
        .is_ext_o     (enc_is_ext),
        .index_o      (enc_index),
        .vector_o     (enc_vector)
    );

    assign request    = enc_valid & sreg_i;
    assign sreg_i_set = reti_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ext_q   <= 1'b0;
            vec_q   <= '0;
            pc_q    <= '0;
            reti_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ext_q   <= ext_d;
            vec_q   <= vec_d;
            pc_q    <= pc_d;
            reti_q  <= (state_q == IDLE) && reti;
        end
    end

    // Winner and return address are frozen at capture; later flag changes wait.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ext_d        = ext_q;
        vec_d        = vec_q;
        pc_d         = pc_q;
        push_req     = 1'b0;
        push_data    = '0;
        hold         = 1'b0;
        pc_overwrite = 1'b0;
        pc_new       = '0;
        flag_clr     = '0;
        sreg_i_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_done && request && !reti) begin
                    state_d = PUSH_LO;
                    idx_d   = enc_index;
                    ext_d   = enc_is_ext;
                    vec_d   = enc_vector;
                    pc_d    = pc;
                end
            end
            PUSH_LO: begin
                hold      = 1'b1;
                push_req  = 1'b1;
                push_data = pc_q[7:0];
                if (push_ack) state_d = PUSH_HI;
            end
            PUSH_HI: begin
                hold      = 1'b1;
                push_req  = 1'b1;
                push_data = 8'(pc_q >> 8);
                if (push_ack) state_d = VECTOR;
            end
            VECTOR: begin
                hold         = 1'b1;
                pc_overwrite = 1'b1;
                pc_new       = vec_q;
                flag_clr     = ext_q ? 8'h00 : (8'h01 << idx_q);
                sreg_i_clr   = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
